draw_scheduler: RTL and testbench

Sequences per-frame rendering into the double-buffered frame buffer. Layer requesters (background, platforms, doodle, …) each present a pixel stream, and the block grants the single frame-buffer write port to one layer at a time in fixed order. On each `frame_clk` rising edge after a frame completes, it swaps display/draw buffers and starts the next frame. It sits between the per-layer pixel generators and the frame-buffer write port.

---
 rtl/draw_pkg.sv | 29 ++
 rtl/frame_tick_sync.sv | 24 ++
 rtl/draw_scheduler.sv | 126 ++++++++++++
 tb/tb_draw_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the per-frame draw scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2,
        SWAP = 2'd3
    } sched_state_t;

    localparam int COORD_W = 10;

    // Visible playfield window; pixels outside it can be dropped when clipping is built in
    localparam int WIN_X_MIN = 80;
    localparam int WIN_X_MAX = 239;
    localparam int WIN_Y_MAX = 239;

    // Draw order, bottom layer first
    localparam int LAYER_BG     = 0;
    localparam int LAYER_PLAT   = 1;
    localparam int LAYER_DOODLE = 2;

    function automatic logic in_window(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (x >= COORD_W'(WIN_X_MIN)) && (x <= COORD_W'(WIN_X_MAX)) && (y <= COORD_W'(WIN_Y_MAX));
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame tick into Clk and emits a one-cycle pulse per rising edge.
// Latency: 3 Clk cycles from frame_clk rising to tick (two sync flops plus registered edge detect).
// Backpressure: none; a tick is never held, consumers must act on it in the cycle it is high.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic [2:0] sync_q;

    // Two-flop synchronizer, third flop keeps the previous level, registered rising-edge pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= '0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk};
            tick   <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Grants the frame-buffer write port to layer requesters in fixed order and swaps buffers per frame.
// Latency: pixel accept to fb_we 1 cycle; tick to frame_start 1 cycle from IDLE, 2 via SWAP.
// Backpressure: fb_ready low holds fb_we/draw_* stable and drops req_ready until the write drains.
// Build option DRAW_SCHED_CLIP_EN: out-of-window pixels complete the handshake but are not written.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int C_W     = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_clk,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0]     req_color,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       frame_start,
    input  logic                       fb_ready,
    output logic                       fb_we,
    output logic [COORD_W-1:0]         draw_x,
    output logic [COORD_W-1:0]         draw_y,
    output logic [C_W-1:0]             draw_color,
    output logic                       buffer_using,
    output logic                       overrun
);

    localparam int CUR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [CUR_W-1:0]     cur;
    logic                 tick;
    logic                 out_free;
    logic                 accept;
    logic                 acc_last;
    logic                 cur_is_last;
    logic                 start_frame;
    logic                 wr_en;
    logic [COORD_W-1:0]   sel_x;
    logic [COORD_W-1:0]   sel_y;
    logic [C_W-1:0]       sel_c;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // The output register can take a new pixel when empty or when its current write drains now
    assign out_free    = !fb_we || fb_ready;
    assign sel_x       = req_x[cur*COORD_W +: COORD_W];
    assign sel_y       = req_y[cur*COORD_W +: COORD_W];
    assign sel_c       = req_color[cur*C_W +: C_W];
    assign accept      = (state == DRAW) && out_free && req_valid[cur];
    assign acc_last    = accept && req_last[cur];
    assign cur_is_last = (32'(cur) == NUM_REQ - 1);
    assign start_frame = ((state == IDLE) && tick) || (state == SWAP);

`ifdef DRAW_SCHED_CLIP_EN
    assign wr_en = in_window(sel_x, sel_y);
`else
    assign wr_en = 1'b1;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: a tick only advances IDLE and DONE; ticks elsewhere are reported as overrun
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = DRAW;
            DRAW:    if (acc_last && cur_is_last) state_nxt = DONE;
            DONE:    if (tick) state_nxt = SWAP;
            SWAP:    state_nxt = DRAW;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant only the layer currently being drawn
    always_comb begin
        req_ready = '0;
        if ((state == DRAW) && out_free) req_ready[cur] = 1'b1;
    end

    // Frame sequencing: layer pointer, buffer select, frame_start and overrun pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur          <= '0;
            frame_start  <= 1'b0;
            buffer_using <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_start <= start_frame;
            overrun     <= tick && ((state == DRAW) || (state == SWAP));
            if (state == SWAP) buffer_using <= ~buffer_using;
            if (start_frame) cur <= '0;
            else if (acc_last && !cur_is_last) cur <= cur + 1'b1;
        end
    end

    // Write register: load on accept, hold until fb_ready, clear when drained with nothing new
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fb_we      <= 1'b0;
            draw_x     <= '0;
            draw_y     <= '0;
            draw_color <= '0;
        end else if (accept && wr_en) begin
            fb_we      <= 1'b1;
            draw_x     <= sel_x;
            draw_y     <= sel_y;
            draw_color <= sel_c;
        end else if (fb_ready) begin
            fb_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomized bench for draw_scheduler: per-layer pixel lists, expected write order and timing constants.
// Writes are checked against the concatenation of layer lists in draw order.
// Grants, stall holding, frame_start latency, swaps, overrun and mid-frame reset are checked.
`timescale 1ns/1ps
module tb_draw_scheduler;
    import draw_pkg::*;

    localparam int N  = 3;
    localparam int CW = 8;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              frame_clk;
    logic [N-1:0]      req_valid;
    logic [N*10-1:0]   req_x;
    logic [N*10-1:0]   req_y;
    logic [N*CW-1:0]   req_color;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              frame_start;
    logic              fb_ready;
    logic              fb_we;
    logic [9:0]        draw_x;
    logic [9:0]        draw_y;
    logic [CW-1:0]     draw_color;
    logic              buffer_using;
    logic              overrun;

    always #5 Clk = ~Clk;

    draw_scheduler #(.NUM_REQ(N), .C_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .req_last(req_last), .req_ready(req_ready), .frame_start(frame_start),
        .fb_ready(fb_ready), .fb_we(fb_we), .draw_x(draw_x), .draw_y(draw_y),
        .draw_color(draw_color), .buffer_using(buffer_using), .overrun(overrun)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each layer's pixel list for the frame and the write order they imply
    logic [9:0]    lx[N][16];
    logic [9:0]    ly[N][16];
    logic [CW-1:0] lc[N][16];
    int            lcnt[N];
    int            sent[N];
    logic [27:0]   exp_q[$];

    function automatic bit model_writes(input int x, input int y);
`ifdef DRAW_SCHED_CLIP_EN
        return !(x < 80 || x > 239 || y > 239);
`else
        return 1'b1;
`endif
    endfunction

    task automatic build_exp();
        exp_q.delete();
        for (int l = 0; l < N; l++) begin
            sent[l] = 0;
            for (int i = 0; i < lcnt[l]; i++)
                if (model_writes(int'(lx[l][i]), int'(ly[l][i]))) exp_q.push_back({lx[l][i], ly[l][i], lc[l][i]});
        end
    endtask

    task automatic gen_frame(input int c0, input int c1, input int c2);
        lcnt[0] = c0; lcnt[1] = c1; lcnt[2] = c2;
        for (int l = 0; l < N; l++)
            for (int i = 0; i < 16; i++) begin
                lx[l][i] = 10'(80 + $urandom_range(159));
                ly[l][i] = 10'($urandom_range(239));
                lc[l][i] = CW'($urandom);
            end
        build_exp();
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_last  = '0;
        fb_ready  = 1'b1;
    endtask

    // Raise frame_clk and expect frame_start after exp_lat rising Clk edges with buffer_using = exp_buf
    task automatic frame_edge(input int exp_lat, input logic exp_buf, input bit toggles);
        logic buf_prev;
        bit   seen;
        seen = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b1;
        buf_prev  = buffer_using;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge Clk); #1;
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                vectors++;
                if (k != exp_lat) begin miscompares++; $display("FAIL frame_start_latency got=%0d want=%0d", k, exp_lat); end
                vectors++;
                if (buffer_using !== exp_buf) begin miscompares++; $display("FAIL buffer_using_at_start got=%b want=%b", buffer_using, exp_buf); end
                vectors++;
                if (buf_prev !== (toggles ? ~exp_buf : exp_buf)) begin miscompares++; $display("FAIL buffer_using_before_start got=%b want=%b", buf_prev, toggles ? ~exp_buf : exp_buf); end
            end else begin
                buf_prev = buffer_using;
            end
        end
        if (!seen) begin vectors++; miscompares++; $display("FAIL frame_start_timeout got=none want=%0d cycles", exp_lat); end
        @(posedge Clk); #1;
        vectors++;
        if (frame_start !== 1'b0) begin miscompares++; $display("FAIL frame_start_width got=%b want=0", frame_start); end
        frame_clk = 1'b0;
    endtask

    // Stream the modelled frame; checks grants, stall holding and write order every cycle
    task automatic stream_frame(input int valid_pct, input int ready_pct, input int stall_lo, input int stall_hi,
                                input int ovr_at, output int n_ovr, output int first_acc, output int last_acc);
        bit          done;
        bit          pend;
        logic [27:0] pdat;
        logic [27:0] got;
        logic [27:0] want;
        logic [N-1:0] allowed;
        int          cur_l;
        done = 1'b0; pend = 1'b0; pdat = '0;
        n_ovr = 0; first_acc = -1; last_acc = -1;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge Clk);
            for (int l = 0; l < N; l++) begin
                if (sent[l] < lcnt[l] && int'($urandom_range(99)) < valid_pct) begin
                    req_valid[l]          = 1'b1;
                    req_x[l*10 +: 10]     = lx[l][sent[l]];
                    req_y[l*10 +: 10]     = ly[l][sent[l]];
                    req_color[l*CW +: CW] = lc[l][sent[l]];
                    req_last[l]           = (sent[l] == lcnt[l] - 1);
                end else begin
                    req_valid[l] = 1'b0;
                    req_last[l]  = 1'($urandom);
                end
            end
            fb_ready = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
            if (cyc == ovr_at) frame_clk = 1'b1;
            if (ovr_at >= 0 && cyc == ovr_at + 6) frame_clk = 1'b0;
            #1;
            cur_l = N;
            for (int l = N - 1; l >= 0; l--) if (sent[l] < lcnt[l]) cur_l = l;
            allowed = (cur_l < N) ? (N'(1) << cur_l) : '0;
            got = {draw_x, draw_y, draw_color};
            vectors++;
            if ((req_ready & ~allowed) !== '0) begin miscompares++; $display("FAIL grant_order got=%b want_subset_of=%b", req_ready, allowed); end
            if (fb_we === 1'b1 && !fb_ready) begin
                vectors++;
                if (req_ready !== '0) begin miscompares++; $display("FAIL ready_during_stall got=%b want=0", req_ready); end
            end
            if (pend) begin
                vectors++;
                if (fb_we !== 1'b1 || got !== pdat) begin miscompares++; $display("FAIL hold_stable got=%b/%h want=1/%h", fb_we, got, pdat); end
            end
            if (cyc >= stall_lo && cyc < stall_hi) begin
                vectors++;
                if (fb_we !== 1'b1) begin miscompares++; $display("FAIL stall_we got=%b want=1", fb_we); end
            end
            if (fb_we === 1'b1 && fb_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL extra_write got=%h want=none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin miscompares++; $display("FAIL write_data got=%h want=%h", got, want); end
                end
            end
            pend = (fb_we === 1'b1) && !fb_ready;
            pdat = got;
            for (int l = 0; l < N; l++)
                if (req_valid[l] && req_ready[l] === 1'b1) begin
                    sent[l]++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            if (overrun === 1'b1) n_ovr++;
            done = (exp_q.size() == 0);
            for (int l = 0; l < N; l++) if (sent[l] < lcnt[l]) done = 1'b0;
        end
        if (!done) begin vectors++; miscompares++; $display("FAIL stream_timeout got=%0d writes pending want=0", exp_q.size()); end
        @(negedge Clk);
        idle_inputs();
        #1;
        vectors++;
        if (fb_we !== 1'b0) begin miscompares++; $display("FAIL we_clear got=%b want=0", fb_we); end
        vectors++;
        if (dut.state !== DONE) begin miscompares++; $display("FAIL state_done got=%0d want=%0d", dut.state, DONE); end
    endtask

    task automatic test_reset();
        Reset = 1'b1; frame_clk = 1'b0;
        req_x = '0; req_y = '0; req_color = '0;
        idle_inputs();
        repeat (3) @(posedge Clk);
        #1;
        vectors += 8;
        if (fb_we !== 1'b0)        begin miscompares++; $display("FAIL reset_fb_we got=%b want=0", fb_we); end
        if (req_ready !== '0)      begin miscompares++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        if (frame_start !== 1'b0)  begin miscompares++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
        if (overrun !== 1'b0)      begin miscompares++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        if (buffer_using !== 1'b0) begin miscompares++; $display("FAIL reset_buffer_using got=%b want=0", buffer_using); end
        if (draw_x !== '0)         begin miscompares++; $display("FAIL reset_draw_x got=%h want=0", draw_x); end
        if (draw_y !== '0)         begin miscompares++; $display("FAIL reset_draw_y got=%h want=0", draw_y); end
        if (draw_color !== '0)     begin miscompares++; $display("FAIL reset_draw_color got=%h want=0", draw_color); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_first_frame();
        frame_edge(4, 1'b0, 1'b0);
    endtask

    task automatic test_layer_order();
        int n, f, l;
        gen_frame(4, 2, 1);
        stream_frame(60, 70, -1, -1, -1, n, f, l);
        vectors++;
        if (n != 0) begin miscompares++; $display("FAIL unexpected_overrun got=%0d want=0", n); end
    endtask

    task automatic test_swap();
        int n, f, l;
        frame_edge(5, 1'b1, 1'b1);
        gen_frame(3, 5, 2);
        stream_frame(70, 60, -1, -1, -1, n, f, l);
        frame_edge(5, 1'b0, 1'b1);
        gen_frame(1, 1, 6);
        stream_frame(80, 50, -1, -1, -1, n, f, l);
    endtask

    task automatic test_back_to_back();
        int n, f, l;
        frame_edge(5, 1'b1, 1'b1);
        gen_frame(4, 2, 1);
        stream_frame(100, 100, -1, -1, -1, n, f, l);
        vectors++;
        if (l - f != 6) begin miscompares++; $display("FAIL throughput got=%0d cycles want=6", l - f); end
    endtask

    task automatic test_stall();
        int n, f, l;
        frame_edge(5, 1'b0, 1'b1);
        gen_frame(1, 1, 1);
        lx[0][0] = 10'd100; ly[0][0] = 10'd50; lc[0][0] = 8'h3F;
        build_exp();
        stream_frame(100, 100, 1, 6, -1, n, f, l);
    endtask

    task automatic test_overrun();
        int n, f, l;
        bit saw_start;
        frame_edge(5, 1'b1, 1'b1);
        gen_frame(2, 10, 2);
        stream_frame(100, 100, -1, -1, 3, n, f, l);
        vectors++;
        if (n != 1) begin miscompares++; $display("FAIL overrun_count got=%0d want=1", n); end
        vectors++;
        if (buffer_using !== 1'b1) begin miscompares++; $display("FAIL overrun_no_swap got=%b want=1", buffer_using); end
        saw_start = 1'b0;
        repeat (10) begin
            @(posedge Clk); #1;
            if (frame_start === 1'b1) saw_start = 1'b1;
        end
        vectors++;
        if (saw_start) begin miscompares++; $display("FAIL dropped_tick_swapped got=1 want=0"); end
        frame_edge(5, 1'b0, 1'b1);
        gen_frame(2, 2, 2);
        stream_frame(90, 90, -1, -1, -1, n, f, l);
    endtask

    task automatic test_clip();
        int n, f, l;
        frame_edge(5, 1'b1, 1'b1);
        gen_frame(2, 1, 1);
        lx[0][0] = 10'd60; ly[0][0] = 10'd10;
        lx[0][1] = 10'd80; ly[0][1] = 10'd239;
        build_exp();
        stream_frame(100, 100, -1, -1, -1, n, f, l);
    endtask

    task automatic test_reset_mid();
        int n, f, l;
        frame_edge(5, 1'b0, 1'b1);
        gen_frame(3, 1, 1);
        @(negedge Clk);
        req_valid = 3'b001; req_last = '0; fb_ready = 1'b0;
        req_x[9:0] = lx[0][0]; req_y[9:0] = ly[0][0]; req_color[CW-1:0] = lc[0][0];
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        vectors += 8;
        if (fb_we !== 1'b0)        begin miscompares++; $display("FAIL midreset_fb_we got=%b want=0", fb_we); end
        if (req_ready !== '0)      begin miscompares++; $display("FAIL midreset_req_ready got=%b want=0", req_ready); end
        if (frame_start !== 1'b0)  begin miscompares++; $display("FAIL midreset_frame_start got=%b want=0", frame_start); end
        if (overrun !== 1'b0)      begin miscompares++; $display("FAIL midreset_overrun got=%b want=0", overrun); end
        if (buffer_using !== 1'b0) begin miscompares++; $display("FAIL midreset_buffer_using got=%b want=0", buffer_using); end
        if (draw_x !== '0)         begin miscompares++; $display("FAIL midreset_draw_x got=%h want=0", draw_x); end
        if (draw_y !== '0)         begin miscompares++; $display("FAIL midreset_draw_y got=%h want=0", draw_y); end
        if (draw_color !== '0)     begin miscompares++; $display("FAIL midreset_draw_color got=%h want=0", draw_color); end
        vectors++;
        if (dut.state !== IDLE) begin miscompares++; $display("FAIL midreset_state got=%0d want=%0d", dut.state, IDLE); end
        @(negedge Clk);
        Reset = 1'b0;
        idle_inputs();
        frame_edge(4, 1'b0, 1'b0);
        gen_frame(1, 1, 1);
        stream_frame(100, 100, -1, -1, -1, n, f, l);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_layer_order();
        test_swap();
        test_back_to_back();
        test_stall();
        test_overrun();
        test_clip();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
